nexys2_uart_rx: RTL and testbench
=================================

# nexys2_uart_rx

Receive-side UART for the Nexys2 RS-232 port. Deserialises `serial_in` (8N1, LSB first) into bytes and presents each byte on a valid/ready output register for consumption by board logic. It sits beside the top level's serial port pins and is the receive counterpart of the `serial_out` path. Line errors (false start, bad stop bit, consumer too slow) are flagged, never silently merged into data.

## Interface
- `CLK_HZ`, 50_000_000: frequency of `clk0` in Hz.
- `BAUD`, 115_200: line rate in bit/s.
- `OVERSAMPLE`, 16: ticks per bit period; fixed at 16 and not overridable.
- `DIV`, derived as round(`CLK_HZ`/(`BAUD`*16)); 27 at the defaults; must be ≥ 2.
- `clk0` input 1: system clock. One clock domain only.
- `reset` input 1: asynchronous, active-high reset.
- `serial_in` input 1: raw RS-232 RX line, asynchronous to `clk0`; idles high.
- `rx_data` output 8: received byte, held stable while `rx_valid`=1.
- `rx_valid` output 1: byte available.
- `rx_ready` input 1: consumer accepts; a transfer occurs on a `clk0` edge where `rx_valid`=1 and `rx_ready`=1.
- `frame_err` output 1: one-cycle pulse; stop bit sampled low.
- `overrun` output 1: one-cycle pulse; a complete byte was dropped because the output register was still full.

## Operation
- Input path: `serial_in` passes through a 2-flop synchroniser; both flops reset to 1. All logic below uses the synchronised bit `rxs`.
- Tick generator: a counter 0..`DIV`-1 produces `tick` for one cycle at `DIV`-1. The counter free-runs and is cleared on entry to START, so that START is phase-aligned to the falling edge.
- Per-bit logic: a 4-bit tick counter `tcnt` counts ticks within each bit. `rxs` is sampled when `tick` occurs with `tcnt`==7, i.e. mid-bit. `tcnt` wraps 15→0 at each bit boundary.
- IDLE: stays here while `rxs`=1. `rxs`=0 → START.
- START: at the mid-bit sample, `rxs`=1 → IDLE (false start, no flag). `rxs`=0 → DATA with `tcnt` continuing and bit index 0.
- DATA: at each mid-bit sample, the sampled bit shifts into the shift register, LSB first. After bit index 7 → STOP.
- STOP: at the mid-bit sample:
  - `rxs`=1 → deliver the byte, then IDLE.
  - `rxs`=0 → pulse `frame_err`, discard the byte, → BREAK.
- BREAK: waits for `rxs`=1, then IDLE. A held-low line (break) therefore produces exactly one `frame_err`.
- Delivery when the output register is empty, or is being drained in the same cycle (`rx_valid`&&`rx_ready`): load `rx_data`, set `rx_valid`.
- Delivery when the output register is full and not being drained: keep the old byte and pulse `overrun`.
- `rx_valid` clears on transfer unless a new byte loads in the same cycle. Simultaneous transfer and load → `rx_valid` stays 1 with the new data.

## Timing
- Reset values: `rx_valid`=0, `rx_data`=8'h00, `frame_err`=0, `overrun`=0, state=IDLE, synchroniser=2'b11.
- Reset mid-frame aborts the frame immediately. After release, the receiver resynchronises on the next falling edge seen in IDLE.
- Latency from a `serial_in` edge to its `rxs` edge is 2 clocks.
- `rx_valid` rises 1 clock after the stop-bit mid-sample, about 9.5 bit periods after the start edge.
- `frame_err` and `overrun` are high for exactly one clock, in the cycle `rx_valid` would otherwise have loaded.
- Sample point is 8 ticks ±1 tick (±`DIV` clocks of synchroniser/phase error) after the detected edge. Tolerated baud mismatch is about ±4 %.

## Structure
- Shared header `uart_defs.vh`:
  - state encodings `UART_IDLE`, `UART_START`, `UART_DATA`, `UART_STOP`, `UART_BREAK`;
  - `UART_OVERSAMPLE`=16 and `UART_MID`=7;
  - the `DIV` rounding expression, for reuse by a future `nexys2_uart_tx`.
- One sub-module, `uart_baud_tick`: parameter `DIV`; ports `clk0`, `reset`, `clear`, `tick`. Shared with the transmitter.
- Top level instantiates `nexys2_uart_rx` on `clk0`/`reset`/`serial_in`.

## Test plan
Bench uses `CLK_HZ`=1_600_000, `BAUD`=25_000, giving `DIV`=4 and 64 clocks per bit.
- Byte 8'hA5 at nominal rate, `rx_ready`=1 → one `rx_valid` pulse with `rx_data`=8'hA5, about 610 clocks after the start edge; no flags.
- Bytes 8'h00, 8'hFF, 8'h55 back-to-back, each with a one-bit stop only → three deliveries in order; no flags.
- Low glitch of 20 clocks on an idle line → returns to IDLE; no `rx_valid`, no flags.
- Byte 8'h3C with stop bit forced low, then line held low for 2000 clocks → exactly one `frame_err`, no `rx_valid`. A later 8'h81 is received correctly.
- `rx_ready`=0 while 8'h11 then 8'h22 arrive → `rx_data` stays 8'h11, one `overrun` pulse during the 8'h22 stop bit. Raising `rx_ready` transfers 8'h11 and clears `rx_valid`.
- Transmitter bit period at 62 and 66 clocks (±3 %) for 8'hC3 → received correctly. `reset` pulsed at bit 4 of a frame → outputs return to reset values, and the next full frame 8'h7E is received.

Source files
------------

// File: rtl/nexys2_uart_rx_pkg.sv
// Shared UART definitions: receiver state encodings, oversampling constants
// and the baud divisor rounding, reusable by a future transmitter.
package nexys2_uart_rx_pkg;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_MID        = 7;

    typedef enum logic [2:0] {
        UART_IDLE  = 3'd0,
        UART_START = 3'd1,
        UART_DATA  = 3'd2,
        UART_STOP  = 3'd3,
        UART_BREAK = 3'd4
    } uart_state_t;

    // round(clk_hz / (baud * 16)); the result must be at least 2
    function automatic int uart_div(input int clk_hz, input int baud);
        return (clk_hz + baud * (UART_OVERSAMPLE / 2)) / (baud * UART_OVERSAMPLE);
    endfunction

endpackage

// File: rtl/nexys2_uart_rx_if.sv
// Receive-side output bundle: byte register with valid/ready plus error pulses.
// A byte transfers on a clk0 edge where rx_valid and rx_ready are both 1;
// rx_data is held stable while rx_valid is 1 and rx_valid never drops
// without a transfer. frame_err and overrun are single-cycle pulses.
interface nexys2_uart_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;

    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
        output overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  overrun,
        output rx_ready
    );
endinterface

// File: rtl/nexys2_uart_rx_baud_tick.sv
// Free-running 16x oversampling tick generator; clear re-phases the count so
// the first tick lands DIV clocks after a detected start edge.
module uart_baud_tick #(
    parameter int DIV = 27
) (
    input  logic clk0,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk0 or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/nexys2_uart_rx.sv
// 8N1 receiver: synchronises serial_in, samples each bit mid-period with a
// 16x tick and hands bytes to a valid/ready register, flagging line errors.
module nexys2_uart_rx
    import nexys2_uart_rx_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115_200
) (
    input  logic                    clk0,
    input  logic                    reset,
    input  logic                    serial_in,
    nexys2_uart_rx_if.master        rx,
    output uart_state_t             state_dbg
);

    localparam int DIV = uart_div(CLK_HZ, BAUD);

    logic [1:0]  sync_q;
    logic        rxs;
    uart_state_t state;
    logic [3:0]  tcnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic        clear;
    logic        tick;
    logic        mid;

    always_ff @(posedge clk0 or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], serial_in};
        end
    end

    assign rxs   = sync_q[1];
    assign clear = (state == UART_IDLE) && !rxs;
    assign mid   = tick && (tcnt == 4'(UART_MID));

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk0  (clk0),
        .reset (reset),
        .clear (clear),
        .tick  (tick)
    );

    always_ff @(posedge clk0 or posedge reset) begin
        if (reset) begin
            state       <= UART_IDLE;
            tcnt        <= 4'd0;
            bit_idx     <= 3'd0;
            shift       <= 8'h00;
            rx.rx_data  <= 8'h00;
            rx.rx_valid <= 1'b0;
            rx.frame_err <= 1'b0;
            rx.overrun  <= 1'b0;
        end else begin
            rx.frame_err <= 1'b0;
            rx.overrun   <= 1'b0;
            if (rx.rx_valid && rx.rx_ready) begin
                rx.rx_valid <= 1'b0;
            end
            if (tick) begin
                tcnt <= tcnt + 4'd1;
            end
            case (state)
                UART_IDLE: begin
                    if (!rxs) begin
                        state <= UART_START;
                        tcnt  <= 4'd0;
                    end
                end
                UART_START: begin
                    if (mid) begin
                        if (rxs) begin
                            state <= UART_IDLE;
                        end else begin
                            state   <= UART_DATA;
                            bit_idx <= 3'd0;
                        end
                    end
                end
                UART_DATA: begin
                    if (mid) begin
                        shift <= {rxs, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= UART_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                UART_STOP: begin
                    if (mid) begin
                        if (rxs) begin
                            state <= UART_IDLE;
                            // a draining register may take the new byte this same cycle
                            if (!rx.rx_valid || rx.rx_ready) begin
                                rx.rx_data  <= shift;
                                rx.rx_valid <= 1'b1;
                            end else begin
                                rx.overrun <= 1'b1;
                            end
                        end else begin
                            rx.frame_err <= 1'b1;
                            state        <= UART_BREAK;
                        end
                    end
                end
                UART_BREAK: begin
                    if (rxs) begin
                        state <= UART_IDLE;
                    end
                end
                default: state <= UART_IDLE;
            endcase
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_nexys2_uart_rx.sv
// Directed bench for nexys2_uart_rx at DIV=4 (64 clocks per bit); a monitor
// pops expected output events from a scoreboard queue as the DUT presents them.
module tb_nexys2_uart_rx;
    import nexys2_uart_rx_pkg::*;

    localparam int BIT_CLKS = 64;

    logic        clk0 = 1'b0;
    logic        reset;
    logic        serial_in;
    uart_state_t state_dbg;

    nexys2_uart_rx_if rx_if ();

    nexys2_uart_rx #(.CLK_HZ(1_600_000), .BAUD(25_000)) dut (
        .clk0      (clk0),
        .reset     (reset),
        .serial_in (serial_in),
        .rx        (rx_if),
        .state_dbg (state_dbg)
    );

    always #5 clk0 = ~clk0;

    int cyc = 0;
    always @(posedge clk0) cyc <= cyc + 1;

    // event word: {kind, data}; kind 0 = byte transfer, 1 = frame_err, 2 = overrun
    logic [9:0] exp_q[$];
    int n_vec = 0;
    int n_miss = 0;
    int last_valid_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_event(input logic [9:0] got);
        logic [9:0] e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL rx_event: got kind %0d data %02h, expected no event", got[9:8], got[7:0]);
        end else begin
            e = exp_q.pop_front();
            chk("rx_event", 32'(got), 32'(e));
        end
    endtask

    // monitor
    always @(negedge clk0) begin
        if (!reset) begin
            if (rx_if.rx_valid && rx_if.rx_ready) begin
                check_event({2'd0, rx_if.rx_data});
                last_valid_cyc = cyc;
            end
            if (rx_if.frame_err) check_event({2'd1, 8'h00});
            if (rx_if.overrun)   check_event({2'd2, rx_if.rx_data});
        end
    end

    initial begin
        repeat (60000) @(posedge clk0);
        $display("FAIL watchdog: simulation exceeded 60000 cycles");
        $fatal(1, "watchdog expired");
    end

    task automatic hold(input logic v, input int n);
        serial_in = v;
        repeat (n) @(posedge clk0);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] b, input int bc, input logic stop_bit);
        hold(1'b0, bc);
        for (int i = 0; i < 8; i++) hold(b[i], bc);
        hold(stop_bit, bc);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_state"},     32'(state_dbg), 32'(UART_IDLE));
        chk({tag, "_rx_valid"},  32'(rx_if.rx_valid), 32'd0);
        chk({tag, "_rx_data"},   32'(rx_if.rx_data), 32'h00);
        chk({tag, "_frame_err"}, 32'(rx_if.frame_err), 32'd0);
        chk({tag, "_overrun"},   32'(rx_if.overrun), 32'd0);
    endtask

    initial begin
        int t0;
        int lat;
        logic [7:0] partial;
        reset = 1'b1;
        serial_in = 1'b1;
        rx_if.rx_ready = 1'b1;
        repeat (4) @(posedge clk0);
        #2;
        check_reset_values("reset");
        reset = 1'b0;
        hold(1'b1, 100);

        // nominal byte and its latency from the start edge
        exp_q.push_back({2'd0, 8'hA5});
        t0 = cyc;
        send_byte(8'hA5, BIT_CLKS, 1'b1);
        hold(1'b1, BIT_CLKS);
        lat = last_valid_cyc - t0;
        n_vec++;
        if (lat < 605 || lat > 617) begin
            n_miss++;
            $display("FAIL a5_latency: got %0d clocks expected 605..617", lat);
        end

        // back-to-back frames with a single stop bit
        exp_q.push_back({2'd0, 8'h00});
        exp_q.push_back({2'd0, 8'hFF});
        exp_q.push_back({2'd0, 8'h55});
        send_byte(8'h00, BIT_CLKS, 1'b1);
        send_byte(8'hFF, BIT_CLKS, 1'b1);
        send_byte(8'h55, BIT_CLKS, 1'b1);
        hold(1'b1, 2 * BIT_CLKS);

        // short low glitch is a false start
        hold(1'b0, 20);
        hold(1'b1, 200);
        chk("glitch_state", 32'(state_dbg), 32'(UART_IDLE));
        chk("glitch_rx_valid", 32'(rx_if.rx_valid), 32'd0);

        // stop bit low followed by a long break
        exp_q.push_back({2'd1, 8'h00});
        send_byte(8'h3C, BIT_CLKS, 1'b0);
        hold(1'b0, 2000);
        chk("break_state", 32'(state_dbg), 32'(UART_BREAK));
        hold(1'b1, 200);
        chk("after_break_state", 32'(state_dbg), 32'(UART_IDLE));
        exp_q.push_back({2'd0, 8'h81});
        send_byte(8'h81, BIT_CLKS, 1'b1);
        hold(1'b1, 2 * BIT_CLKS);

        // consumer stalled: second byte overruns, first is kept
        rx_if.rx_ready = 1'b0;
        exp_q.push_back({2'd2, 8'h11});
        exp_q.push_back({2'd0, 8'h11});
        send_byte(8'h11, BIT_CLKS, 1'b1);
        hold(1'b1, BIT_CLKS);
        send_byte(8'h22, BIT_CLKS, 1'b1);
        hold(1'b1, 2 * BIT_CLKS);
        chk("stall_rx_valid", 32'(rx_if.rx_valid), 32'd1);
        chk("stall_rx_data", 32'(rx_if.rx_data), 32'h11);
        rx_if.rx_ready = 1'b1;
        repeat (3) @(posedge clk0);
        #2;
        chk("drained_rx_valid", 32'(rx_if.rx_valid), 32'd0);

        // baud mismatch of about +/-3 %
        exp_q.push_back({2'd0, 8'hC3});
        send_byte(8'hC3, 62, 1'b1);
        hold(1'b1, 2 * BIT_CLKS);
        exp_q.push_back({2'd0, 8'hC3});
        send_byte(8'hC3, 66, 1'b1);
        hold(1'b1, 2 * BIT_CLKS);

        // reset during bit 4 of a frame
        partial = 8'h0F;
        hold(1'b0, BIT_CLKS);
        for (int i = 0; i < 4; i++) hold(partial[i], BIT_CLKS);
        hold(partial[4], 30);
        chk("midframe_state", 32'(state_dbg), 32'(UART_DATA));
        reset = 1'b1;
        serial_in = 1'b1;
        repeat (3) @(posedge clk0);
        #2;
        check_reset_values("midreset");
        reset = 1'b0;
        hold(1'b1, 200);
        exp_q.push_back({2'd0, 8'h7E});
        send_byte(8'h7E, BIT_CLKS, 1'b1);
        hold(1'b1, 2 * BIT_CLKS);

        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(posedge clk0);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
